tcdm_to_axi_bridge: RTL and testbench

Protocol converter from one 32-bit TCDM (XBAR_TCDM_BUS) slave port to a 32-bit AXI4 master port. It is the counterpart of the SoC interconnect's AXI→TCDM bridge and carries SoC-side TCDM initiators (FC, uDMA, debug) onto AXI targets such as the cluster plug or wide ALU. Every TCDM request becomes one single-beat AXI transaction, and responses are returned to TCDM in issue order.

---
 rtl/tcdm_to_axi_bridge.sv | 180 ++++++++++++++++++
 tb/tb_tcdm_to_axi_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_to_axi_bridge.sv
// Single-beat TCDM -> AXI4 protocol converter; responses return in issue order.
// Optional macro TCDM2AXI_ERR_OPC_EN forwards AXI resp[1] onto tcdm_r_opc_o.
module tcdm_to_axi_bridge #(
  parameter int AXI_ID_WIDTH    = 1,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tcdm_req_i,
  output logic                      tcdm_gnt_o,
  input  logic [31:0]               tcdm_add_i,
  input  logic                      tcdm_wen_i,
  input  logic [31:0]               tcdm_wdata_i,
  input  logic [3:0]                tcdm_be_i,
  output logic                      tcdm_r_valid_o,
  output logic [31:0]               tcdm_r_rdata_o,
  output logic                      tcdm_r_opc_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [31:0]               aw_addr_o,
  output logic [2:0]                aw_prot_o,
  output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
  output logic [7:0]                aw_len_o,
  output logic [2:0]                aw_size_o,
  output logic [1:0]                aw_burst_o,
  output logic                      aw_lock_o,
  output logic [3:0]                aw_cache_o,
  output logic [3:0]                aw_qos_o,
  output logic [3:0]                aw_region_o,
  output logic [5:0]                aw_atop_o,
  output logic [AXI_USER_WIDTH-1:0] aw_user_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [31:0]               w_data_o,
  output logic [3:0]                w_strb_o,
  output logic                      w_last_o,
  output logic [AXI_USER_WIDTH-1:0] w_user_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [1:0]                b_resp_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [31:0]               ar_addr_o,
  output logic [2:0]                ar_prot_o,
  output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  output logic                      ar_lock_o,
  output logic [3:0]                ar_cache_o,
  output logic [3:0]                ar_qos_o,
  output logic [3:0]                ar_region_o,
  output logic [AXI_USER_WIDTH-1:0] ar_user_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [31:0]               r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             is_wr_reg;
  logic             aw_valid_reg, w_valid_reg, ar_valid_reg;
  logic [31:0]      aw_addr_reg, ar_addr_reg, w_data_reg;
  logic [3:0]       w_strb_reg;
  logic             r_valid_reg, r_opc_reg;
  logic [31:0]      r_rdata_reg;

  logic gnt, wr_gnt, rd_gnt, type_ok, slot_free;
  logic rsp_b, rsp_r, rsp_take, opc_in;
  logic unused_inputs;

  assign unused_inputs = ^{r_last_i, b_resp_i, r_resp_i};

  // A slot counts as free while its handshake completes, so one request per cycle can stream.
  always_comb begin
    type_ok   = (cnt_reg == '0) || (is_wr_reg == ~tcdm_wen_i);
    slot_free = tcdm_wen_i ? (!ar_valid_reg || ar_ready_i)
                           : ((!aw_valid_reg || aw_ready_i) && (!w_valid_reg || w_ready_i));
    gnt       = tcdm_req_i && (cnt_reg < CNT_MAX) && type_ok && slot_free;
    wr_gnt    = gnt && !tcdm_wen_i;
    rd_gnt    = gnt && tcdm_wen_i;
    // Stray or wrong-type beats are accepted and dropped so a stalled slave cannot alias later requests.
    rsp_b     = b_valid_i && (cnt_reg != '0) && is_wr_reg;
    rsp_r     = r_valid_i && (cnt_reg != '0) && !is_wr_reg;
    rsp_take  = rsp_b || rsp_r;
`ifdef TCDM2AXI_ERR_OPC_EN
    opc_in    = rsp_b ? b_resp_i[1] : r_resp_i[1];
`else
    opc_in    = 1'b0;
`endif
    cnt_next  = cnt_reg;
    if (gnt && !rsp_take)
      cnt_next = cnt_reg + CNT_W'(1);
    else if (!gnt && rsp_take)
      cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      is_wr_reg    <= 1'b0;
      aw_valid_reg <= 1'b0;
      w_valid_reg  <= 1'b0;
      ar_valid_reg <= 1'b0;
      aw_addr_reg  <= '0;
      ar_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      r_valid_reg  <= 1'b0;
      r_rdata_reg  <= '0;
      r_opc_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      r_valid_reg <= rsp_take;
      if (gnt) is_wr_reg <= ~tcdm_wen_i;
      if (wr_gnt) begin
        aw_valid_reg <= 1'b1;
        aw_addr_reg  <= {tcdm_add_i[31:2], 2'b00};
        w_valid_reg  <= 1'b1;
        w_data_reg   <= tcdm_wdata_i;
        w_strb_reg   <= tcdm_be_i;
      end else begin
        if (aw_ready_i) aw_valid_reg <= 1'b0;
        if (w_ready_i)  w_valid_reg  <= 1'b0;
      end
      if (rd_gnt) begin
        ar_valid_reg <= 1'b1;
        ar_addr_reg  <= {tcdm_add_i[31:2], 2'b00};
      end else if (ar_ready_i) begin
        ar_valid_reg <= 1'b0;
      end
      if (rsp_take) begin
        r_rdata_reg <= rsp_r ? r_data_i : 32'h0;
        r_opc_reg   <= opc_in;
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_reg;
  assign tcdm_r_rdata_o = r_rdata_reg;
  assign tcdm_r_opc_o   = r_opc_reg;
  assign b_ready_o      = 1'b1;
  assign r_ready_o      = 1'b1;

  assign aw_valid_o  = aw_valid_reg;
  assign aw_addr_o   = aw_addr_reg;
  assign aw_prot_o   = 3'b000;
  assign aw_id_o     = '0;
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = 3'b010;
  assign aw_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_qos_o    = 4'd0;
  assign aw_region_o = 4'd0;
  assign aw_atop_o   = 6'd0;
  assign aw_user_o   = '0;
  assign w_valid_o   = w_valid_reg;
  assign w_data_o    = w_data_reg;
  assign w_strb_o    = w_strb_reg;
  assign w_last_o    = 1'b1;
  assign w_user_o    = '0;
  assign ar_valid_o  = ar_valid_reg;
  assign ar_addr_o   = ar_addr_reg;
  assign ar_prot_o   = 3'b000;
  assign ar_id_o     = '0;
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = 3'b010;
  assign ar_burst_o  = 2'b01;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_qos_o    = 4'd0;
  assign ar_region_o = 4'd0;
  assign ar_user_o   = '0;
endmodule

// File: tb/tb_tcdm_to_axi_bridge.sv
// Self-checking bench for tcdm_to_axi_bridge: scenario tasks drive TCDM/AXI stimulus,
// a scoreboard queue holds expected TCDM responses, compared when tcdm_r_valid_o fires.
module tb_tcdm_to_axi_bridge;
  typedef struct packed {
    logic [31:0] rdata;
    logic        opc;
  } rsp_t;

`ifdef TCDM2AXI_ERR_OPC_EN
  localparam logic ERR_OPC = 1'b1;
`else
  localparam logic ERR_OPC = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic tcdm_req_i, tcdm_gnt_o, tcdm_wen_i;
  logic [31:0] tcdm_add_i, tcdm_wdata_i;
  logic [3:0] tcdm_be_i;
  logic tcdm_r_valid_o, tcdm_r_opc_o;
  logic [31:0] tcdm_r_rdata_o;
  logic aw_valid_o, aw_ready_i, aw_lock_o;
  logic [31:0] aw_addr_o;
  logic [2:0] aw_prot_o, aw_size_o;
  logic [0:0] aw_id_o, ar_id_o;
  logic [7:0] aw_len_o, ar_len_o;
  logic [1:0] aw_burst_o, ar_burst_o;
  logic [3:0] aw_cache_o, aw_qos_o, aw_region_o;
  logic [5:0] aw_atop_o, aw_user_o, w_user_o, ar_user_o;
  logic w_valid_o, w_ready_i, w_last_o;
  logic [31:0] w_data_o;
  logic [3:0] w_strb_o;
  logic b_valid_i, b_ready_o;
  logic [1:0] b_resp_i, r_resp_i;
  logic ar_valid_o, ar_ready_i, ar_lock_o;
  logic [31:0] ar_addr_o;
  logic [2:0] ar_prot_o, ar_size_o;
  logic [3:0] ar_cache_o, ar_qos_o, ar_region_o;
  logic r_valid_i, r_ready_o, r_last_i;
  logic [31:0] r_data_i;

  int   vectors = 0;
  int   miscompares = 0;
  rsp_t sb[$];

  tcdm_to_axi_bridge #(.AXI_ID_WIDTH(1), .AXI_USER_WIDTH(6), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tcdm_req_i(tcdm_req_i), .tcdm_gnt_o(tcdm_gnt_o), .tcdm_add_i(tcdm_add_i),
    .tcdm_wen_i(tcdm_wen_i), .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i),
    .tcdm_r_valid_o(tcdm_r_valid_o), .tcdm_r_rdata_o(tcdm_r_rdata_o), .tcdm_r_opc_o(tcdm_r_opc_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
    .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_qos_o(aw_qos_o), .aw_region_o(aw_region_o),
    .aw_atop_o(aw_atop_o), .aw_user_o(aw_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o), .w_user_o(w_user_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_qos_o(ar_qos_o), .ar_region_o(ar_region_o),
    .ar_user_o(ar_user_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_last_i(r_last_i)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every TCDM response must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && tcdm_r_valid_o) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got rdata=%h opc=%b, required no response", tcdm_r_rdata_o, tcdm_r_opc_o);
      end else begin
        rsp_t exp_rsp;
        exp_rsp = sb.pop_front();
        if ({tcdm_r_rdata_o, tcdm_r_opc_o} !== {exp_rsp.rdata, exp_rsp.opc}) begin
          miscompares++;
          $display("FAIL rsp: got rdata=%h opc=%b, required rdata=%h opc=%b",
                   tcdm_r_rdata_o, tcdm_r_opc_o, exp_rsp.rdata, exp_rsp.opc);
        end else begin
          $display("rsp  rdata=%h opc=%b t=%0t", tcdm_r_rdata_o, tcdm_r_opc_o, $time);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    tcdm_req_i = 0; tcdm_wen_i = 1; tcdm_add_i = 0; tcdm_wdata_i = 0; tcdm_be_i = 0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
    b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    repeat (3) next_cycle();
    @(negedge clk_i);
    vectors++;
    if ({aw_valid_o, w_valid_o, ar_valid_o, tcdm_r_valid_o, tcdm_r_opc_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_valids: got %b required 00000", {aw_valid_o, w_valid_o, ar_valid_o, tcdm_r_valid_o, tcdm_r_opc_o});
    end
    vectors++;
    if ({tcdm_r_rdata_o, aw_addr_o, ar_addr_o, w_data_o, w_strb_o} !== 132'h0) begin
      miscompares++;
      $display("FAIL reset_payload: got rdata=%h aw=%h ar=%h wd=%h strb=%h required all 0",
               tcdm_r_rdata_o, aw_addr_o, ar_addr_o, w_data_o, w_strb_o);
    end
    vectors++;
    if ({w_last_o, aw_size_o, ar_size_o, aw_burst_o, ar_burst_o, aw_len_o, aw_prot_o, aw_atop_o, ar_user_o}
        !== {1'b1, 3'b010, 3'b010, 2'b01, 2'b01, 8'd0, 3'd0, 6'd0, 6'd0}) begin
      miscompares++;
      $display("FAIL const_fields: got last=%b size=%b/%b burst=%b/%b len=%h prot=%b atop=%h user=%h required 1 010 01 0",
               w_last_o, aw_size_o, ar_size_o, aw_burst_o, ar_burst_o, aw_len_o, aw_prot_o, aw_atop_o, ar_user_o);
    end
    next_cycle();
    rst_i = 0;
  endtask

  task automatic test_read();
    next_cycle();
    tcdm_req_i = 1; tcdm_wen_i = 1; tcdm_add_i = 32'h1A10_0006; ar_ready_i = 1;
    @(negedge clk_i);
    vectors++;
    if (tcdm_gnt_o !== 1'b1) begin miscompares++; $display("FAIL read_gnt: got %b required 1", tcdm_gnt_o); end
    sb.push_back('{rdata: 32'hDEAD_BEEF, opc: 1'b0});
    next_cycle();
    tcdm_req_i = 0;
    @(negedge clk_i);
    vectors++;
    if ({ar_valid_o, ar_addr_o} !== {1'b1, 32'h1A10_0004}) begin
      miscompares++;
      $display("FAIL read_ar: got valid=%b addr=%h required 1 1a100004", ar_valid_o, ar_addr_o);
    end
    next_cycle();
    ar_ready_i = 0; r_valid_i = 1; r_data_i = 32'hDEAD_BEEF; r_resp_i = 2'b00;
    @(negedge clk_i);
    vectors++;
    if ({ar_valid_o, r_ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL read_ar_done: got ar_valid=%b r_ready=%b required 0 1", ar_valid_o, r_ready_o);
    end
    next_cycle();
    r_valid_i = 0;
    @(negedge clk_i);
    vectors++;
    if (tcdm_r_valid_o !== 1'b1) begin miscompares++; $display("FAIL read_latency3: got r_valid=%b required 1", tcdm_r_valid_o); end
    next_cycle();
    @(negedge clk_i);
    vectors++;
    if (tcdm_r_valid_o !== 1'b0) begin miscompares++; $display("FAIL read_pulse: got r_valid=%b required 0", tcdm_r_valid_o); end
  endtask

  task automatic test_write();
    next_cycle();
    tcdm_req_i = 1; tcdm_wen_i = 0; tcdm_add_i = 32'h1C00_0010; tcdm_wdata_i = 32'h1234_5678; tcdm_be_i = 4'b0011;
    @(negedge clk_i);
    vectors++;
    if (tcdm_gnt_o !== 1'b1) begin miscompares++; $display("FAIL write_gnt: got %b required 1", tcdm_gnt_o); end
    sb.push_back('{rdata: 32'h0, opc: 1'b0});
    next_cycle();
    tcdm_req_i = 0; w_ready_i = 1;
    @(negedge clk_i);
    vectors++;
    if ({aw_valid_o, w_valid_o, aw_addr_o, w_data_o, w_strb_o} !== {2'b11, 32'h1C00_0010, 32'h1234_5678, 4'b0011}) begin
      miscompares++;
      $display("FAIL write_payload: got v=%b%b aw=%h wd=%h strb=%b required 11 1c000010 12345678 0011",
               aw_valid_o, w_valid_o, aw_addr_o, w_data_o, w_strb_o);
    end
    next_cycle();
    w_ready_i = 0;
    @(negedge clk_i);
    vectors++;
    if ({aw_valid_o, w_valid_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL write_w_first: got aw_valid=%b w_valid=%b required 1 0", aw_valid_o, w_valid_o);
    end
    next_cycle();
    aw_ready_i = 1;
    next_cycle();
    aw_ready_i = 0; b_valid_i = 1; b_resp_i = 2'b00;
    @(negedge clk_i);
    vectors++;
    if (aw_valid_o !== 1'b0) begin miscompares++; $display("FAIL write_aw_done: got %b required 0", aw_valid_o); end
    next_cycle();
    b_valid_i = 0;
    @(negedge clk_i);
    vectors++;
    if (tcdm_r_valid_o !== 1'b1) begin miscompares++; $display("FAIL write_rsp: got r_valid=%b required 1", tcdm_r_valid_o); end
    next_cycle();
    @(negedge clk_i);
    vectors++;
    if (tcdm_r_valid_o !== 1'b0) begin miscompares++; $display("FAIL write_single_b: got r_valid=%b required 0", tcdm_r_valid_o); end
  endtask

  // Five reads against MAX_OUTSTANDING=4 with R held back until the pipe is full.
  task automatic test_back_to_back();
    logic [31:0] rd [5];
    int          nr;
    for (int k = 0; k < 5; k++) rd[k] = 32'hA500_0000 + 32'(k * 17);
    ar_ready_i = 1;
    nr = 0;
    for (int i = 0; i < 11; i++) begin
      logic exp_gnt;
      next_cycle();
      tcdm_req_i = (i < 7);
      tcdm_wen_i = 1;
      tcdm_add_i = 32'h2000_0000 + 32'((i < 4 ? i : 4) * 4);
      r_valid_i  = (i >= 5) && (i <= 9);
      r_data_i   = (i >= 5 && i <= 9) ? rd[i - 5] : 32'h0;
      exp_gnt    = (i < 4) || (i == 6);
      @(negedge clk_i);
      if (tcdm_req_i) begin
        vectors++;
        if (tcdm_gnt_o !== exp_gnt) begin
          miscompares++;
          $display("FAIL b2b_gnt[%0d]: got %b required %b", i, tcdm_gnt_o, exp_gnt);
        end
      end
      if (exp_gnt) begin
        sb.push_back('{rdata: rd[nr], opc: 1'b0});
        nr++;
      end
    end
    idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk_i);
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_drain: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_mixed_types();
    next_cycle();
    tcdm_req_i = 1; tcdm_wen_i = 1; tcdm_add_i = 32'h3000_0008; ar_ready_i = 1;
    @(negedge clk_i);
    vectors++;
    if (tcdm_gnt_o !== 1'b1) begin miscompares++; $display("FAIL mix_rd_gnt: got %b required 1", tcdm_gnt_o); end
    sb.push_back('{rdata: 32'h0BAD_F00D, opc: 1'b0});
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tcdm_wen_i = 0; tcdm_add_i = 32'h3000_0100; tcdm_wdata_i = 32'hCAFE_0001; tcdm_be_i = 4'hF;
      r_valid_i = (i == 1); r_data_i = 32'h0BAD_F00D;
      @(negedge clk_i);
      vectors++;
      if (tcdm_gnt_o !== (i == 2)) begin
        miscompares++;
        $display("FAIL mix_wr_gnt[%0d]: got %b required %b", i, tcdm_gnt_o, (i == 2));
      end
      if (i == 2) begin
        vectors++;
        if (tcdm_r_valid_o !== 1'b1) begin miscompares++; $display("FAIL mix_rvalid: got %b required 1", tcdm_r_valid_o); end
      end
    end
    sb.push_back('{rdata: 32'h0, opc: 1'b0});
    next_cycle();
    tcdm_req_i = 0; ar_ready_i = 0; aw_ready_i = 1; w_ready_i = 1;
    next_cycle();
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1;
    next_cycle();
    b_valid_i = 0;
    repeat (2) next_cycle();
  endtask

  task automatic test_error_resp();
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      tcdm_req_i = 1; tcdm_wen_i = (k == 1); tcdm_add_i = 32'h4000_0040; tcdm_wdata_i = 32'h5555_AAAA; tcdm_be_i = 4'hF;
      @(negedge clk_i);
      vectors++;
      if (tcdm_gnt_o !== 1'b1) begin miscompares++; $display("FAIL err_gnt[%0d]: got %b required 1", k, tcdm_gnt_o); end
      sb.push_back('{rdata: (k == 1) ? 32'h7777_1234 : 32'h0, opc: ERR_OPC});
      next_cycle();
      tcdm_req_i = 0; aw_ready_i = 1; w_ready_i = 1; ar_ready_i = 1;
      next_cycle();
      aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
      b_valid_i = (k == 0); b_resp_i = 2'b10;
      r_valid_i = (k == 1); r_resp_i = 2'b11; r_data_i = 32'h7777_1234;
      next_cycle();
      b_valid_i = 0; r_valid_i = 0; b_resp_i = 0; r_resp_i = 0;
      @(negedge clk_i);
      vectors++;
      if (tcdm_r_valid_o !== 1'b1) begin miscompares++; $display("FAIL err_rvalid[%0d]: got %b required 1", k, tcdm_r_valid_o); end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    ar_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      tcdm_req_i = 1; tcdm_wen_i = 1; tcdm_add_i = 32'h5000_0000 + 32'(i * 4);
    end
    next_cycle();
    tcdm_req_i = 0; ar_ready_i = 0; rst_i = 1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      rst_i = 0;
      r_valid_i = (i < 2); r_data_i = 32'hBADB_AD00 + 32'(i);
      @(negedge clk_i);
      vectors++;
      if (tcdm_r_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_drop[%0d]: got r_valid=%b required 0", i, tcdm_r_valid_o); end
    end
    // A write is only granted right after reset if nothing is counted as in flight.
    next_cycle();
    tcdm_req_i = 1; tcdm_wen_i = 0; tcdm_add_i = 32'h5000_0020; tcdm_wdata_i = 32'h0; tcdm_be_i = 4'h1;
    @(negedge clk_i);
    vectors++;
    if (tcdm_gnt_o !== 1'b1) begin miscompares++; $display("FAIL rst_cnt_zero: got gnt=%b required 1", tcdm_gnt_o); end
    sb.push_back('{rdata: 32'h0, opc: 1'b0});
    next_cycle();
    tcdm_req_i = 0; aw_ready_i = 1; w_ready_i = 1;
    next_cycle();
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1;
    next_cycle();
    b_valid_i = 0;
    next_cycle();
    tcdm_req_i = 1; tcdm_wen_i = 1; tcdm_add_i = 32'h5000_0033; ar_ready_i = 1;
    @(negedge clk_i);
    vectors++;
    if (tcdm_gnt_o !== 1'b1) begin miscompares++; $display("FAIL rst_next_gnt: got %b required 1", tcdm_gnt_o); end
    sb.push_back('{rdata: 32'h600D_0001, opc: 1'b0});
    next_cycle();
    tcdm_req_i = 0;
    @(negedge clk_i);
    vectors++;
    if (ar_addr_o !== 32'h5000_0030) begin miscompares++; $display("FAIL rst_next_addr: got %h required 50000030", ar_addr_o); end
    next_cycle();
    ar_ready_i = 0; r_valid_i = 1; r_data_i = 32'h600D_0001;
    next_cycle();
    r_valid_i = 0;
    @(negedge clk_i);
    vectors++;
    if (tcdm_r_valid_o !== 1'b1) begin miscompares++; $display("FAIL rst_next_rsp: got r_valid=%b required 1", tcdm_r_valid_o); end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_mixed_types();
    test_error_resp();
    test_reset_mid();
    idle_inputs();
    repeat (4) next_cycle();
    @(negedge clk_i);
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL final_drain: got %0d pending required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
